// File: rtl/trigger_conditioner.sv
// External trigger conditioner: synchroniser, glitch filter, rising-edge detect,
// and arm/holdoff/shot-count gating that produces a one-cycle trig pulse.
module trigger_conditioner #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 8,
  parameter int HOLDOFF_CYCLES = 70000,
  parameter int HOLDOFF_W      = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ext_trig,
  input  logic        arm,
  input  logic [15:0] shots,
  output logic        trig,
  output logic        armed,
  output logic        busy,
  output logic        done,
  output logic        missed,
  output logic [15:0] shot_count
);

  localparam int FW = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES);
  localparam logic [FW-1:0]        FILT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [HOLDOFF_W-1:0] HOLD_INIT = HOLDOFF_W'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ARMED, HOLDOFF, DONE} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_v;
  logic [FW-1:0]          filt_cnt;
  logic                   level, level_d;
  logic                   rise;
  logic [HOLDOFF_W-1:0]   hold_cnt;
  logic [15:0]            shots_lat;
  logic                   fire, start, miss_set, hold_dec;

  assign sync_v = sync_q[SYNC_STAGES-1];
  assign rise   = level & ~level_d;

  // Level only flips after FILTER_CYCLES consecutive samples disagree with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      filt_cnt <= '0;
      level    <= 1'b0;
      level_d  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ext_trig};
      level_d <= level;
      if (sync_v != level) begin
        if (filt_cnt == FILT_LAST) begin
          level    <= sync_v;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    fire     = 1'b0;
    start    = 1'b0;
    miss_set = 1'b0;
    hold_dec = 1'b0;
    case (state)
      IDLE: begin
        if (arm) begin
          state_n = ARMED;
          start   = 1'b1;
        end
      end
      ARMED: begin
        if (!arm) state_n = IDLE;
        else if (rise) begin
          fire    = 1'b1;
          state_n = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (!arm) state_n = IDLE;
        else begin
          if (rise) miss_set = 1'b1;
          if (hold_cnt == '0) begin
            if (shots_lat != 16'd0 && shot_count == shots_lat) state_n = DONE;
            else                                               state_n = ARMED;
          end else begin
            hold_dec = 1'b1;
          end
        end
      end
      DONE: begin
        if (!arm) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig       <= 1'b0;
      armed      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      missed     <= 1'b0;
      shot_count <= '0;
      shots_lat  <= '0;
      hold_cnt   <= '0;
    end else begin
      trig  <= fire;
      armed <= (state_n == ARMED) || (state_n == HOLDOFF);
      busy  <= (state_n == HOLDOFF);
      done  <= (state_n == DONE);
      if (start) begin
        shots_lat  <= shots;
        shot_count <= '0;
        missed     <= 1'b0;
      end
      if (fire) begin
        shot_count <= shot_count + 16'd1;
        hold_cnt   <= HOLD_INIT;
      end else if (hold_dec) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      if (miss_set) missed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_trigger_conditioner.sv
// Directed test of trigger_conditioner with HOLDOFF_CYCLES=100 (trig latency 11).
module tb_trigger_conditioner;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ext_trig = 1'b0;
  logic        arm = 1'b0;
  logic [15:0] shots = '0;
  logic        trig, armed, busy, done, missed;
  logic [15:0] shot_count;

  int nasrt = 0;
  int nfail = 0;
  int ntrig = 0;
  bit ok;

  trigger_conditioner #(
    .SYNC_STAGES(2), .FILTER_CYCLES(8), .HOLDOFF_CYCLES(100), .HOLDOFF_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ext_trig(ext_trig), .arm(arm), .shots(shots),
    .trig(trig), .armed(armed), .busy(busy), .done(done), .missed(missed),
    .shot_count(shot_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (trig) ntrig++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_trig(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (trig === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("rst_trig", trig, 0);
    chk("rst_armed", armed, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_missed", missed, 0);
    chk("rst_shot_count", shot_count, 0);
    rst_n = 1'b1;
    tick(3);

    // Glitch shorter than the filter
    shots = 16'd1;
    arm = 1'b1;
    tick();
    chk("arm_armed", armed, 1);
    ext_trig = 1'b1;
    tick(7);
    ext_trig = 1'b0;
    tick(20);
    chk("glitch_ntrig", ntrig, 0);
    chk("glitch_missed", missed, 0);
    chk("glitch_shot_count", shot_count, 0);

    // Single shot: exact latency, one-cycle pulse, DONE after holdoff
    ext_trig = 1'b1;
    tick(10);
    chk("lat_early", trig, 0);
    tick();
    chk("lat_trig", trig, 1);
    chk("single_shot_count", shot_count, 1);
    chk("single_busy", busy, 1);
    tick();
    chk("single_pulse_width", trig, 0);
    tick(98);
    chk("hold_end_busy", busy, 1);
    chk("hold_end_done", done, 0);
    tick();
    chk("done_done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_armed", armed, 0);
    ext_trig = 1'b0;
    tick(20);
    ext_trig = 1'b1;
    tick(20);
    chk("done_ntrig", ntrig, 1);
    chk("done_missed", missed, 0);

    // Holdoff miss with shots=3
    arm = 1'b0;
    tick();
    chk("disarm_done", done, 0);
    chk("disarm_armed", armed, 0);
    shots = 16'd3;
    arm = 1'b1;
    tick();
    chk("rearm_shot_count", shot_count, 0);
    ext_trig = 1'b0;
    tick(15);
    ext_trig = 1'b1;
    wait_trig(ok);
    chk("miss_first_trig", ok, 1);
    chk("miss_first_count", shot_count, 1);
    ext_trig = 1'b0;
    tick(38);
    ext_trig = 1'b1;
    tick(21);
    chk("miss_missed", missed, 1);
    chk("miss_ntrig", ntrig, 2);
    chk("miss_count", shot_count, 1);
    chk("miss_busy", busy, 1);
    ext_trig = 1'b0;
    tick(49);
    ext_trig = 1'b1;
    wait_trig(ok);
    chk("after_hold_trig", ok, 1);
    chk("after_hold_count", shot_count, 2);
    chk("after_hold_missed", missed, 1);

    // Abort mid-holdoff, then re-arm
    tick(10);
    arm = 1'b0;
    tick();
    chk("abort_armed", armed, 0);
    chk("abort_busy", busy, 0);
    chk("abort_count_held", shot_count, 2);
    chk("abort_missed_held", missed, 1);
    arm = 1'b1;
    tick();
    chk("rearm2_armed", armed, 1);
    chk("rearm2_count", shot_count, 0);
    chk("rearm2_missed", missed, 0);

    // Asynchronous reset mid-holdoff
    ext_trig = 1'b0;
    tick(15);
    ext_trig = 1'b1;
    wait_trig(ok);
    chk("pre_reset_trig", ok, 1);
    tick(5);
    chk("pre_reset_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    arm = 1'b0;
    ext_trig = 1'b0;
    #1;
    chk("areset_trig", trig, 0);
    chk("areset_armed", armed, 0);
    chk("areset_busy", busy, 0);
    chk("areset_done", done, 0);
    chk("areset_missed", missed, 0);
    chk("areset_count", shot_count, 0);
    tick();
    rst_n = 1'b1;
    tick(3);

    // Continuous mode never reaches DONE
    shots = 16'd0;
    arm = 1'b1;
    tick();
    for (int k = 1; k <= 3; k++) begin
      ext_trig = 1'b0;
      tick(110);
      ext_trig = 1'b1;
      wait_trig(ok);
      chk("cont_trig", ok, 1);
      chk("cont_count", shot_count, k);
      chk("cont_done", done, 0);
    end
    ext_trig = 1'b0;
    tick(110);
    chk("cont_end_done", done, 0);
    chk("cont_end_armed", armed, 1);
    chk("cont_end_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end
endmodule
